// File: rtl/erx_burst_unpack_pkg.sv
// Shared elink definitions: emesh packet layout, datamode encoding and burst stride.
package erx_burst_unpack_pkg;

    localparam int PKT_W        = 104;

    localparam int OFS_ACCESS   = 0;
    localparam int OFS_WRITE    = 1;
    localparam int OFS_DATAMODE = 2;
    localparam int OFS_CTRLMODE = 4;
    localparam int OFS_DSTADDR  = 8;
    localparam int OFS_DATA     = 40;
    localparam int OFS_SRCADDR  = 72;

    localparam logic [1:0] DMODE_BYTE   = 2'b00;
    localparam logic [1:0] DMODE_HALF   = 2'b01;
    localparam logic [1:0] DMODE_WORD   = 2'b10;
    localparam logic [1:0] DMODE_DOUBLE = 2'b11;

    localparam logic [31:0] BURST_STRIDE = 32'd8;

    // Field order mirrors the bit offsets above, MSB first.
    typedef struct packed {
        logic [31:0] srcaddr;
        logic [31:0] data;
        logic [31:0] dstaddr;
        logic [3:0]  ctrlmode;
        logic [1:0]  datamode;
        logic        write;
        logic        access;
    } pkt_t;

endpackage

// File: rtl/erx_burst_unpack_if.sv
// Bundle of the RX input stream, the write/read output channels and the error flags.
interface erx_burst_unpack_if #(parameter int PW = 104);

    logic          rx_access;
    logic          rx_burst;
    logic [PW-1:0] rx_packet;
    logic          rx_wr_wait;
    logic          rx_rd_wait;
    logic          wr_access;
    logic [PW-1:0] wr_packet;
    logic          wr_wait;
    logic          rd_access;
    logic [PW-1:0] rd_packet;
    logic          rd_wait;
    logic          err_burst;
    logic          err_overflow;
    logic          err_clear;

    modport master (
        output rx_access, rx_burst, rx_packet, wr_wait, rd_wait, err_clear,
        input  rx_wr_wait, rx_rd_wait, wr_access, wr_packet, rd_access, rd_packet,
               err_burst, err_overflow
    );

    modport slave (
        input  rx_access, rx_burst, rx_packet, wr_wait, rd_wait, err_clear,
        output rx_wr_wait, rx_rd_wait, wr_access, wr_packet, rd_access, rd_packet,
               err_burst, err_overflow
    );

endinterface

// File: rtl/erx_chan_fifo.sv
// DEPTH-entry channel buffer with registered almost-full; head visible the cycle after push.
// A push into a full buffer lands only alongside a pop, otherwise it is dropped and flagged.
module erx_chan_fifo #(
    parameter int DEPTH = 4,
    parameter int PW    = 104,
    parameter int AFULL = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [PW-1:0] i_push_dat,
    input  logic          i_pop,
    output logic          o_vld,
    output logic [PW-1:0] o_head,
    output logic          o_afull,
    output logic          o_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL);

    logic [PW-1:0] r_mem [DEPTH];
    logic [CW-1:0] r_wr_ptr;
    logic [CW-1:0] r_rd_ptr;
    logic          r_afull;

    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_nxt;
    logic          w_empty;
    logic          w_full;
    logic          w_push_acc;
    logic          w_pop_acc;

    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign w_empty     = (w_count == '0);
    assign w_full      = (w_count == DEPTH_C);
    assign w_pop_acc   = i_pop & ~w_empty;
    assign w_push_acc  = i_push & (~w_full | w_pop_acc);
    assign w_count_nxt = w_count + {{AW{1'b0}}, w_push_acc} - {{AW{1'b0}}, w_pop_acc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_afull  <= 1'b0;
        end else begin
            if (w_push_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_afull <= (w_count_nxt >= AFULL_C);
        end
    end

    // Storage needs no reset: the head is masked whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (w_push_acc) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
    end

    assign o_vld   = ~w_empty;
    assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_afull = r_afull;
    assign o_drop  = i_push & ~w_push_acc;

endmodule

// File: rtl/erx_burst_unpack.sv
// Rebuilds burst dstaddrs and splits RX traffic into write/read channels; 2-cycle latency.
// Input cannot stall: pushback comes from registered almost-full, overflowing packets are dropped.
module erx_burst_unpack
    import erx_burst_unpack_pkg::*;
#(
    parameter int PW    = 104,
    parameter int DEPTH = 4,
    parameter int AFULL = 2
) (
    input  logic              rx_lclk_div4,
    input  logic              erx_reset,
    erx_burst_unpack_if.slave bus
);

    pkt_t        w_in;
    pkt_t        w_dec;
    logic        w_is_wr;
    logic        w_burst_hit;
    logic        w_burst_err;
    logic [31:0] w_dst;

    logic        r_s1_vld;
    logic        r_s1_wr;
    pkt_t        r_s1_pkt;
    logic        r_burst_ok;
    logic [31:0] r_last_addr;
    logic        r_err_burst;
    logic        r_err_ovf;

    logic        w_wr_vld;
    logic        w_rd_vld;
    logic        w_wr_afull;
    logic        w_rd_afull;
    logic        w_wr_drop;
    logic        w_rd_drop;
    logic [PW-1:0] w_wr_head;
    logic [PW-1:0] w_rd_head;

    assign w_in    = pkt_t'(bus.rx_packet);
    assign w_is_wr = w_in.write;

    // Only a write continuing a double-word write may reuse the tracked address.
    assign w_burst_hit = bus.rx_burst & r_burst_ok & w_is_wr;
    assign w_burst_err = bus.rx_access & bus.rx_burst & ~w_burst_hit;
    assign w_dst       = w_burst_hit ? (r_last_addr + BURST_STRIDE) : w_in.dstaddr;

    always_comb begin
        w_dec         = w_in;
        w_dec.dstaddr = w_dst;
    end

    always_ff @(posedge rx_lclk_div4 or posedge erx_reset) begin
        if (erx_reset) begin
            r_s1_vld    <= 1'b0;
            r_s1_wr     <= 1'b0;
            r_s1_pkt    <= '0;
            r_burst_ok  <= 1'b0;
            r_last_addr <= '0;
        end else begin
            r_s1_vld <= bus.rx_access;
            if (bus.rx_access) begin
                r_s1_wr  <= w_is_wr;
                r_s1_pkt <= w_dec;
                if (w_is_wr) begin
                    r_last_addr <= w_dst;
                    r_burst_ok  <= (w_in.datamode == DMODE_DOUBLE);
                end else begin
                    r_burst_ok  <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge rx_lclk_div4 or posedge erx_reset) begin
        if (erx_reset) begin
            r_err_burst <= 1'b0;
            r_err_ovf   <= 1'b0;
        end else begin
            if (w_burst_err)         r_err_burst <= 1'b1;
            else if (bus.err_clear)  r_err_burst <= 1'b0;
            if (w_wr_drop | w_rd_drop) r_err_ovf <= 1'b1;
            else if (bus.err_clear)    r_err_ovf <= 1'b0;
        end
    end

    erx_chan_fifo #(.DEPTH(DEPTH), .PW(PW), .AFULL(AFULL)) u_wr_fifo (
        .clk        (rx_lclk_div4),
        .rst        (erx_reset),
        .i_push     (r_s1_vld & r_s1_wr),
        .i_push_dat (PW'(r_s1_pkt)),
        .i_pop      (~bus.wr_wait),
        .o_vld      (w_wr_vld),
        .o_head     (w_wr_head),
        .o_afull    (w_wr_afull),
        .o_drop     (w_wr_drop)
    );

    erx_chan_fifo #(.DEPTH(DEPTH), .PW(PW), .AFULL(AFULL)) u_rd_fifo (
        .clk        (rx_lclk_div4),
        .rst        (erx_reset),
        .i_push     (r_s1_vld & ~r_s1_wr),
        .i_push_dat (PW'(r_s1_pkt)),
        .i_pop      (~bus.rd_wait),
        .o_vld      (w_rd_vld),
        .o_head     (w_rd_head),
        .o_afull    (w_rd_afull),
        .o_drop     (w_rd_drop)
    );

    assign bus.wr_access    = w_wr_vld;
    assign bus.wr_packet    = w_wr_head;
    assign bus.rd_access    = w_rd_vld;
    assign bus.rd_packet    = w_rd_head;
    assign bus.rx_wr_wait   = w_wr_afull;
    assign bus.rx_rd_wait   = w_rd_afull;
    assign bus.err_burst    = r_err_burst;
    assign bus.err_overflow = r_err_ovf;

endmodule
